llc_set_bufs: RTL and testbench

LLC_SET_BUFS -- requirements
Module: llc_set_bufs

---
 rtl/llc_set_bufs.sv | 139 +++++++++++++
 tb/tb_llc_set_bufs.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/llc_set_bufs.sv
// Per-set staging buffers for the LLC: DEPTH slots each holding a full set of ways,
// loaded in one shot, patched per field, and released back to the free pool.
module llc_set_bufs #(
    parameter int WAYS    = 16,
    parameter int DEPTH   = 4,
    parameter int LINE_W  = 128,
    parameter int TAG_W   = 20,
    parameter int STATE_W = 3,
    parameter int OWNER_W = 4,
    localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1,
    localparam int SLOT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               clr_all,
    input  logic                               ld_valid,
    output logic                               ld_ready,
    output logic [SLOT_W-1:0]                  ld_slot,
    input  logic [WAYS-1:0][LINE_W-1:0]        ld_line,
    input  logic [WAYS-1:0][TAG_W-1:0]         ld_tag,
    input  logic [WAYS-1:0][STATE_W-1:0]       ld_state,
    input  logic [WAYS-1:0][OWNER_W-1:0]       ld_owner,
    input  logic [WAYS-1:0]                    ld_dirty,
    input  logic [WAY_W-1:0]                   ld_evict_way,
    input  logic [SLOT_W-1:0]                  wr_slot,
    input  logic [WAY_W-1:0]                   wr_way,
    input  logic                               wr_en_line,
    input  logic                               wr_en_tag,
    input  logic                               wr_en_state,
    input  logic                               wr_en_owner,
    input  logic                               wr_en_dirty,
    input  logic [LINE_W-1:0]                  wr_line,
    input  logic [TAG_W-1:0]                   wr_tag,
    input  logic [STATE_W-1:0]                 wr_state,
    input  logic [OWNER_W-1:0]                 wr_owner,
    input  logic                               wr_dirty,
    input  logic                               incr_evict,
    input  logic [SLOT_W-1:0]                  incr_slot,
    input  logic                               rel_valid,
    input  logic [SLOT_W-1:0]                  rel_slot,
    input  logic [SLOT_W-1:0]                  rd_slot,
    output logic [WAYS-1:0][LINE_W-1:0]        rd_line,
    output logic [WAYS-1:0][TAG_W-1:0]         rd_tag,
    output logic [WAYS-1:0][STATE_W-1:0]       rd_state,
    output logic [WAYS-1:0][OWNER_W-1:0]       rd_owner,
    output logic [WAYS-1:0]                    rd_dirty,
    output logic [WAY_W-1:0]                   rd_evict_way,
    output logic [DEPTH-1:0]                   slot_busy,
    output logic                               rel_err
);

    localparam logic [WAY_W:0]   WAYS_C   = (WAY_W + 1)'(WAYS);
    localparam logic [SLOT_W:0]  DEPTH_C  = (SLOT_W + 1)'(DEPTH);
    localparam logic [WAY_W-1:0] LAST_WAY = WAY_W'(WAYS - 1);

    logic [DEPTH-1:0][WAYS-1:0][LINE_W-1:0]  line_q;
    logic [DEPTH-1:0][WAYS-1:0][TAG_W-1:0]   tag_q;
    logic [DEPTH-1:0][WAYS-1:0][STATE_W-1:0] state_q;
    logic [DEPTH-1:0][WAYS-1:0][OWNER_W-1:0] owner_q;
    logic [DEPTH-1:0][WAYS-1:0]              dirty_q;
    logic [DEPTH-1:0][WAY_W-1:0]             evict_q;
    logic [DEPTH-1:0]                        busy_q;

    logic way_ok;
    logic rd_ok;
    logic rel_hit;

    assign way_ok    = ({1'b0, wr_way} < WAYS_C);
    assign rd_ok     = ({1'b0, rd_slot} < DEPTH_C);
    assign slot_busy = busy_q;

    // Free-slot search walks downward so the lowest free index wins.
    always_comb begin
        ld_ready = 1'b0;
        ld_slot  = '0;
        rel_hit  = 1'b0;
        for (int s = DEPTH - 1; s >= 0; s--) begin
            if (!busy_q[s]) begin
                ld_ready = 1'b1;
                ld_slot  = SLOT_W'(s);
            end
            if (rel_valid && rel_slot == SLOT_W'(s) && busy_q[s]) begin
                rel_hit = 1'b1;
            end
        end
    end

    always_comb begin
        rd_line      = rd_ok ? line_q[rd_slot]  : '0;
        rd_tag       = rd_ok ? tag_q[rd_slot]   : '0;
        rd_state     = rd_ok ? state_q[rd_slot] : '0;
        rd_owner     = rd_ok ? owner_q[rd_slot] : '0;
        rd_dirty     = rd_ok ? dirty_q[rd_slot] : '0;
        rd_evict_way = rd_ok ? evict_q[rd_slot] : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst || clr_all) begin
            line_q  <= '0;
            tag_q   <= '0;
            state_q <= '0;
            owner_q <= '0;
            dirty_q <= '0;
            evict_q <= '0;
            busy_q  <= '0;
            rel_err <= 1'b0;
        end else begin
            if (rel_valid && !rel_hit) begin
                rel_err <= 1'b1;
            end
            // Release beats load beats patching; a released slot drops its patches.
            for (int s = 0; s < DEPTH; s++) begin
                if (rel_valid && rel_slot == SLOT_W'(s) && busy_q[s]) begin
                    busy_q[s] <= 1'b0;
                end else if (ld_valid && ld_ready && ld_slot == SLOT_W'(s)) begin
                    line_q[s]  <= ld_line;
                    tag_q[s]   <= ld_tag;
                    state_q[s] <= ld_state;
                    owner_q[s] <= ld_owner;
                    dirty_q[s] <= ld_dirty;
                    evict_q[s] <= ld_evict_way;
                    busy_q[s]  <= 1'b1;
                end else if (busy_q[s]) begin
                    if (wr_slot == SLOT_W'(s) && way_ok) begin
                        if (wr_en_line)  line_q[s][wr_way]  <= wr_line;
                        if (wr_en_tag)   tag_q[s][wr_way]   <= wr_tag;
                        if (wr_en_state) state_q[s][wr_way] <= wr_state;
                        if (wr_en_owner) owner_q[s][wr_way] <= wr_owner;
                        if (wr_en_dirty) dirty_q[s][wr_way] <= wr_dirty;
                    end
                    if (incr_evict && incr_slot == SLOT_W'(s)) begin
                        evict_q[s] <= (evict_q[s] >= LAST_WAY) ? '0 : evict_q[s] + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_llc_set_bufs.sv
// Bench for llc_set_bufs with 12 ways (non-power-of-two wrap and out-of-range way writes).
module tb_llc_set_bufs;

    localparam int WAYS = 12, DEPTH = 4, LINE_W = 128, TAG_W = 20, STATE_W = 3, OWNER_W = 4;
    localparam int WAY_W = 4, SLOT_W = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic clr_all, ld_valid, ld_ready;
    logic [SLOT_W-1:0] ld_slot;
    logic [WAYS-1:0][LINE_W-1:0]  ld_line;
    logic [WAYS-1:0][TAG_W-1:0]   ld_tag;
    logic [WAYS-1:0][STATE_W-1:0] ld_state;
    logic [WAYS-1:0][OWNER_W-1:0] ld_owner;
    logic [WAYS-1:0] ld_dirty;
    logic [WAY_W-1:0] ld_evict_way;
    logic [SLOT_W-1:0] wr_slot;
    logic [WAY_W-1:0] wr_way;
    logic wr_en_line, wr_en_tag, wr_en_state, wr_en_owner, wr_en_dirty;
    logic [LINE_W-1:0] wr_line;
    logic [TAG_W-1:0] wr_tag;
    logic [STATE_W-1:0] wr_state;
    logic [OWNER_W-1:0] wr_owner;
    logic wr_dirty, incr_evict, rel_valid, rel_err;
    logic [SLOT_W-1:0] incr_slot, rel_slot, rd_slot;
    logic [WAYS-1:0][LINE_W-1:0]  rd_line;
    logic [WAYS-1:0][TAG_W-1:0]   rd_tag;
    logic [WAYS-1:0][STATE_W-1:0] rd_state;
    logic [WAYS-1:0][OWNER_W-1:0] rd_owner;
    logic [WAYS-1:0] rd_dirty;
    logic [WAY_W-1:0] rd_evict_way;
    logic [DEPTH-1:0] slot_busy;

    always #5 clk = ~clk;

    llc_set_bufs #(.WAYS(WAYS), .DEPTH(DEPTH), .LINE_W(LINE_W), .TAG_W(TAG_W),
                   .STATE_W(STATE_W), .OWNER_W(OWNER_W)) dut (
        .clk(clk), .rst(rst), .clr_all(clr_all),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_slot(ld_slot),
        .ld_line(ld_line), .ld_tag(ld_tag), .ld_state(ld_state), .ld_owner(ld_owner),
        .ld_dirty(ld_dirty), .ld_evict_way(ld_evict_way),
        .wr_slot(wr_slot), .wr_way(wr_way),
        .wr_en_line(wr_en_line), .wr_en_tag(wr_en_tag), .wr_en_state(wr_en_state),
        .wr_en_owner(wr_en_owner), .wr_en_dirty(wr_en_dirty),
        .wr_line(wr_line), .wr_tag(wr_tag), .wr_state(wr_state), .wr_owner(wr_owner),
        .wr_dirty(wr_dirty), .incr_evict(incr_evict), .incr_slot(incr_slot),
        .rel_valid(rel_valid), .rel_slot(rel_slot), .rd_slot(rd_slot),
        .rd_line(rd_line), .rd_tag(rd_tag), .rd_state(rd_state), .rd_owner(rd_owner),
        .rd_dirty(rd_dirty), .rd_evict_way(rd_evict_way),
        .slot_busy(slot_busy), .rel_err(rel_err)
    );

    int n_cmp = 0;
    int n_mis = 0;

    // Reference contents of every slot, updated from the documented rules.
    bit [LINE_W-1:0]  m_line [DEPTH][WAYS];
    bit [TAG_W-1:0]   m_tag  [DEPTH][WAYS];
    bit [STATE_W-1:0] m_state[DEPTH][WAYS];
    bit [OWNER_W-1:0] m_owner[DEPTH][WAYS];
    bit               m_dirty[DEPTH][WAYS];
    int               m_ev   [DEPTH];
    bit               m_busy [DEPTH];
    bit               m_err;

    typedef struct {
        logic ld; logic rel; logic [1:0] rs; logic [TAG_W-1:0] tag;
        logic [3:0] busy; logic rdy; logic [1:0] slot;
    } vec_t;
    vec_t tbl[7];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int first_free();
        for (int s = 0; s < DEPTH; s++) if (!m_busy[s]) return s;
        return -1;
    endfunction

    task automatic model_step();
        int fs, ws, wy, is, rs;
        bit rh;
        if (!rst || clr_all) begin
            for (int s = 0; s < DEPTH; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    m_line[s][w] = '0; m_tag[s][w] = '0; m_state[s][w] = '0;
                    m_owner[s][w] = '0; m_dirty[s][w] = 1'b0;
                end
                m_ev[s] = 0; m_busy[s] = 1'b0;
            end
            m_err = 1'b0;
            return;
        end
        rs = int'(rel_slot); ws = int'(wr_slot); wy = int'(wr_way); is = int'(incr_slot);
        rh = rel_valid && m_busy[rs];
        if (rel_valid && !rh) m_err = 1'b1;
        fs = first_free();
        if (m_busy[ws] && wy < WAYS && !(rh && rs == ws)) begin
            if (wr_en_line)  m_line[ws][wy]  = wr_line;
            if (wr_en_tag)   m_tag[ws][wy]   = wr_tag;
            if (wr_en_state) m_state[ws][wy] = wr_state;
            if (wr_en_owner) m_owner[ws][wy] = wr_owner;
            if (wr_en_dirty) m_dirty[ws][wy] = wr_dirty;
        end
        if (incr_evict && m_busy[is] && !(rh && rs == is)) m_ev[is] = (m_ev[is] + 1) % WAYS;
        if (ld_valid && fs >= 0) begin
            for (int w = 0; w < WAYS; w++) begin
                m_line[fs][w] = ld_line[w]; m_tag[fs][w] = ld_tag[w];
                m_state[fs][w] = ld_state[w]; m_owner[fs][w] = ld_owner[w];
                m_dirty[fs][w] = ld_dirty[w];
            end
            m_ev[fs] = int'(ld_evict_way);
            m_busy[fs] = 1'b1;
        end
        if (rh) m_busy[rs] = 1'b0;
    endtask

    task automatic check_all();
        int fs, r;
        logic [3:0] eb;
        fs = first_free();
        r = int'(rd_slot);
        for (int s = 0; s < DEPTH; s++) eb[s] = m_busy[s];
        chk("ld_ready", ld_ready, (fs >= 0) ? 1 : 0);
        chk("ld_slot", ld_slot, (fs >= 0) ? fs : 0);
        chk("slot_busy", slot_busy, eb);
        chk("rel_err", rel_err, m_err);
        chk("rd_evict_way", rd_evict_way, m_ev[r]);
        for (int w = 0; w < WAYS; w++) begin
            chk($sformatf("rd_line[%0d]", w),  rd_line[w],  m_line[r][w]);
            chk($sformatf("rd_tag[%0d]", w),   rd_tag[w],   m_tag[r][w]);
            chk($sformatf("rd_state[%0d]", w), rd_state[w], m_state[r][w]);
            chk($sformatf("rd_owner[%0d]", w), rd_owner[w], m_owner[r][w]);
            chk($sformatf("rd_dirty[%0d]", w), rd_dirty[w], m_dirty[r][w]);
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic idle();
        rst = 1'b1; clr_all = 1'b0; ld_valid = 1'b0; rel_valid = 1'b0; incr_evict = 1'b0;
        wr_en_line = 1'b0; wr_en_tag = 1'b0; wr_en_state = 1'b0; wr_en_owner = 1'b0;
        wr_en_dirty = 1'b0; wr_slot = '0; wr_way = '0; incr_slot = '0; rel_slot = '0;
    endtask

    task automatic set_ld(input logic [TAG_W-1:0] tag0, input int ev);
        for (int w = 0; w < WAYS; w++) begin
            ld_line[w]  = {$urandom, $urandom, $urandom, $urandom};
            ld_tag[w]   = TAG_W'($urandom);
            ld_state[w] = STATE_W'($urandom);
            ld_owner[w] = OWNER_W'($urandom);
            ld_dirty[w] = 1'($urandom);
        end
        ld_tag[0] = tag0;
        ld_evict_way = WAY_W'(ev);
    endtask

    task automatic rand_wr();
        wr_line = {$urandom, $urandom, $urandom, $urandom};
        wr_tag = TAG_W'($urandom); wr_state = STATE_W'($urandom);
        wr_owner = OWNER_W'($urandom); wr_dirty = 1'($urandom);
    endtask

    initial begin
        int ev_exp[3];
        logic [LINE_W-1:0] keep_line;
        tbl[0] = '{1'b1, 1'b0, 2'd0, 20'h00101, 4'b0001, 1'b1, 2'd1};
        tbl[1] = '{1'b1, 1'b0, 2'd0, 20'h00102, 4'b0011, 1'b1, 2'd2};
        tbl[2] = '{1'b1, 1'b0, 2'd0, 20'h00103, 4'b0111, 1'b1, 2'd3};
        tbl[3] = '{1'b1, 1'b0, 2'd0, 20'h00104, 4'b1111, 1'b0, 2'd0};
        tbl[4] = '{1'b1, 1'b0, 2'd0, 20'h00105, 4'b1111, 1'b0, 2'd0};
        tbl[5] = '{1'b0, 1'b1, 2'd2, 20'h00000, 4'b1011, 1'b1, 2'd2};
        tbl[6] = '{1'b1, 1'b0, 2'd0, 20'h005A5, 4'b1111, 1'b0, 2'd0};
        ev_exp = '{11, 0, 1};

        idle(); rand_wr(); set_ld('0, 0); rd_slot = '0;
        rst = 1'b0;
        cycle(); cycle();
        chk("reset_ready", ld_ready, 1);
        chk("reset_slot", ld_slot, 0);
        chk("reset_busy", slot_busy, 0);

        // Fill, refused fifth load, release and reuse of slot 2.
        for (int i = 0; i < 7; i++) begin
            idle();
            ld_valid = tbl[i].ld;
            set_ld(tbl[i].tag, 0);
            rel_valid = tbl[i].rel; rel_slot = tbl[i].rs;
            rd_slot = 2'($urandom);
            cycle();
            chk($sformatf("tbl%0d_busy", i), slot_busy, tbl[i].busy);
            chk($sformatf("tbl%0d_ready", i), ld_ready, tbl[i].rdy);
            chk($sformatf("tbl%0d_slot", i), ld_slot, tbl[i].slot);
        end
        idle(); rd_slot = 2'd2; #1;
        chk("reuse_tag", rd_tag[0], 20'h005A5);
        rd_slot = 2'd0; #1;
        chk("slot0_tag", rd_tag[0], 20'h00101);

        // Evict pointer wraps at WAYS-1.
        rst = 1'b0; cycle(); idle();
        ld_valid = 1'b1; set_ld(20'h00AAA, 10); rd_slot = 2'd0;
        cycle();
        for (int k = 0; k < 3; k++) begin
            idle(); incr_evict = 1'b1; incr_slot = 2'd0;
            cycle();
            chk("evict_wrap", rd_evict_way, ev_exp[k]);
        end

        // Write colliding with release of the same slot is dropped.
        idle(); ld_valid = 1'b1; set_ld(20'h00BBB, 0); keep_line = ld_line[3];
        cycle();
        idle(); rand_wr(); wr_line = ~keep_line; wr_en_line = 1'b1; wr_slot = 2'd1; wr_way = 4'd3;
        rel_valid = 1'b1; rel_slot = 2'd1; rd_slot = 2'd1;
        cycle();
        chk("coll_busy1", slot_busy[1], 0);
        chk("coll_line", rd_line[3], keep_line);
        idle(); rel_valid = 1'b1; rel_slot = 2'd0; cycle();
        chk("rel_ok_noerr", rel_err, 0);
        idle(); rel_valid = 1'b1; rel_slot = 2'd0; cycle();
        chk("rel_free_err", rel_err, 1);
        idle(); cycle(); cycle();
        chk("rel_err_sticky", rel_err, 1);
        idle(); clr_all = 1'b1; cycle();
        chk("clr_err", rel_err, 0);

        // Single-field write touches only state[0][5].
        idle(); ld_valid = 1'b1; set_ld(20'h00CCC, 4); rd_slot = 2'd0; cycle();
        idle(); rand_wr(); wr_state = 3'b101; wr_en_state = 1'b1; wr_slot = 2'd0; wr_way = 4'd5;
        cycle();
        chk("iso_state5", rd_state[5], 3'b101);

        // Reset on the cycle of an accepted load discards it.
        idle(); ld_valid = 1'b1; set_ld(20'h00DDD, 3); rst = 1'b0; rd_slot = 2'd1;
        cycle();
        chk("rstld_busy", slot_busy, 0);
        chk("rstld_ready", ld_ready, 1);
        chk("rstld_tag", rd_tag[0], 0);

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            idle();
            rst = ($urandom_range(0, 60) != 0);
            clr_all = ($urandom_range(0, 50) == 0);
            ld_valid = ($urandom_range(0, 2) != 0);
            set_ld(TAG_W'($urandom), $urandom_range(0, WAYS - 1));
            rel_valid = ($urandom_range(0, 3) == 0);
            rel_slot = 2'($urandom);
            rand_wr();
            wr_en_line = 1'($urandom); wr_en_tag = 1'($urandom); wr_en_state = 1'($urandom);
            wr_en_owner = 1'($urandom); wr_en_dirty = 1'($urandom);
            wr_slot = 2'($urandom); wr_way = 4'($urandom_range(0, 15));
            incr_evict = 1'($urandom); incr_slot = 2'($urandom);
            rd_slot = 2'($urandom);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
